// File: rtl/rv16_div.sv
// rv16_div: iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock
module rv16_div #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic [1:0]      i_div_op,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_div_by_zero
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem, quo, dvsr, a_raw;
    logic            is_rem, a_neg, b_neg, dz;
    logic            sgn, b_zero;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_fix, r_fix, res_nxt;
    assign sgn     = ~i_div_op[0];
    assign b_zero  = i_operand_b == '0;
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr};
    assign q_fix   = (a_neg ^ b_neg) ? -quo : quo;
    assign r_fix   = a_neg ? -rem : rem;
    assign res_nxt = dz ? (is_rem ? a_raw : '1) : (is_rem ? r_fix : q_fix);
    assign o_busy  = state != IDLE;
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end
    // next state: zero divisor skips straight to DONE, otherwise XLEN CALC cycles
    always_comb begin
        state_nxt = state == IDLE ? (i_start ? (b_zero ? DONE : CALC) : IDLE)
                  : state == CALC ? (cnt == CW'(XLEN-1) ? DONE : CALC)
                  : IDLE;
    end
    // operand capture, shift/trial-subtract iteration and result registration
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvsr          <= '0;
            a_raw         <= '0;
            is_rem        <= 1'b0;
            a_neg         <= 1'b0;
            b_neg         <= 1'b0;
            dz            <= 1'b0;
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state == IDLE && i_start) begin
                is_rem <= i_div_op[1];
                a_neg  <= sgn & i_operand_a[XLEN-1];
                b_neg  <= sgn & i_operand_b[XLEN-1];
                quo    <= (sgn & i_operand_a[XLEN-1]) ? -i_operand_a : i_operand_a;
                dvsr   <= (sgn & i_operand_b[XLEN-1]) ? -i_operand_b : i_operand_b;
                a_raw  <= i_operand_a;
                dz     <= b_zero;
                rem    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                rem <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], ~diff[XLEN]};
                cnt <= cnt + 1'b1;
            end else if (state == DONE) begin
                o_result      <= res_nxt;
                o_div_by_zero <= dz;
                o_valid       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rv16_div.sv
// tb_rv16_div: scenario tasks plus randomized checks against an arithmetic reference model
module tb_rv16_div;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_operand_a = '0;
    logic [31:0] i_operand_b = '0;
    logic [1:0]  i_div_op = '0;
    logic        o_busy, o_valid, o_div_by_zero;
    logic [31:0] o_result;
    int compared = 0;
    int mismatched = 0;

    rv16_div #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
        .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_div_op(i_div_op),
        .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result), .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;

    // returns {div_by_zero, result} from plain RISC-V arithmetic rules
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint sa, sb, ua, ub;
        logic [31:0] r;
        if (b == 32'd0) return {1'b1, op[1] ? a : 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            2'd0:    r = 32'(sa / sb);
            2'd1:    r = 32'(ua / ub);
            2'd2:    r = 32'(sa % sb);
            default: r = 32'(ua % ub);
        endcase
        return {1'b0, r};
    endfunction

    // issues one request from the current (idle) cycle and waits for o_valid; lat=-1 on timeout
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          output logic [31:0] res, output logic dz, output int lat);
        i_start = 1'b1; i_operand_a = a; i_operand_b = b; i_div_op = op;
        @(posedge clk); #1;
        i_start = 1'b0; i_operand_a = $urandom; i_operand_b = $urandom; i_div_op = 2'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (o_valid) begin lat = n; break; end
        end
        res = o_result;
        dz = o_div_by_zero;
    endtask

    task automatic test_reset;
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", o_busy); end
        compared++; if (o_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", o_valid); end
        compared++; if (o_result !== 32'd0) begin mismatched++; $display("FAIL reset_result got %h want 0", o_result); end
        compared++; if (o_div_by_zero !== 1'b0) begin mismatched++; $display("FAIL reset_dz got %b want 0", o_div_by_zero); end
    endtask

    task automatic test_directed;
        logic [31:0] ta [6] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] tb [6] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd2};
        logic [1:0]  to [6] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};
        logic [31:0] te [6] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFC};
        logic [31:0] res;
        logic dz;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], to[i], res, dz, lat);
            compared++; if (res !== te[i]) begin mismatched++; $display("FAIL directed_%0d result got %h want %h", i, res, te[i]); end
            compared++; if (dz !== 1'b0) begin mismatched++; $display("FAIL directed_%0d dz got %b want 0", i, dz); end
            compared++; if (lat != 33) begin mismatched++; $display("FAIL directed_%0d latency got %0d want 33", i, lat); end
            if (i == 0) begin
                @(posedge clk); #1;
                compared++; if (o_valid !== 1'b0) begin mismatched++; $display("FAIL valid_pulse got %b want 0", o_valid); end
                compared++; if (o_result !== 32'd14) begin mismatched++; $display("FAIL result_hold got %h want %h", o_result, 32'd14); end
            end
        end
    endtask

    task automatic test_div_by_zero;
        logic [31:0] ta [4] = '{32'd5, 32'hFFFF_FFFB, 32'd7, 32'h1234_5678};
        logic [1:0]  to [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
        logic [31:0] te [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] res;
        logic dz;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], 32'd0, to[i], res, dz, lat);
            compared++; if (res !== te[i]) begin mismatched++; $display("FAIL dz_%0d result got %h want %h", i, res, te[i]); end
            compared++; if (dz !== 1'b1) begin mismatched++; $display("FAIL dz_%0d flag got %b want 1", i, dz); end
            compared++; if (lat != 1) begin mismatched++; $display("FAIL dz_%0d latency got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] res;
        logic dz;
        int lat;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'd0, res, dz, lat);
        compared++; if (res !== 32'h8000_0000) begin mismatched++; $display("FAIL ovf_div got %h want 80000000", res); end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'd2, res, dz, lat);
        compared++; if (res !== 32'd0) begin mismatched++; $display("FAIL ovf_rem got %h want 0", res); end
        compared++; if (dz !== 1'b0) begin mismatched++; $display("FAIL ovf_dz got %b want 0", dz); end
    endtask

    task automatic test_handshake;
        int lat = -1;
        int extra = 0;
        i_start = 1'b1; i_operand_a = 32'd100; i_operand_b = 32'd7; i_div_op = 2'd1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5 || n == 20) begin
                i_start = 1'b1; i_operand_a = 32'd1000 + 32'(n); i_operand_b = 32'd0; i_div_op = 2'd0;
            end
            @(posedge clk); #1;
            i_start = 1'b0;
            if (o_valid) begin lat = n; break; end
        end
        compared++; if (lat != 33) begin mismatched++; $display("FAIL hs_latency got %0d want 33", lat); end
        compared++; if (o_result !== 32'd14) begin mismatched++; $display("FAIL hs_result got %h want %h", o_result, 32'd14); end
        for (int n = 0; n < 36; n++) begin
            @(posedge clk); #1;
            if (o_valid) extra++;
        end
        compared++; if (extra != 0) begin mismatched++; $display("FAIL hs_extra_valid got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        logic dz;
        int lat;
        run_op(32'd1000, 32'd9, 2'd1, res, dz, lat);
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL b2b_busy_in_valid got %b want 0", o_busy); end
        compared++; if (res !== 32'd111) begin mismatched++; $display("FAIL b2b_first got %h want %h", res, 32'd111); end
        run_op(32'hDEAD_BEEF, 32'd16, 2'd3, res, dz, lat);
        compared++; if (lat != 33) begin mismatched++; $display("FAIL b2b_latency got %0d want 33", lat); end
        compared++; if (res !== 32'hF) begin mismatched++; $display("FAIL b2b_second got %h want f", res); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] res;
        logic dz;
        int lat;
        int seen = 0;
        i_start = 1'b1; i_operand_a = 32'hFFFF_FFFF; i_operand_b = 32'd3; i_div_op = 2'd1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy got %b want 0", o_busy); end
        compared++; if (o_valid !== 1'b0) begin mismatched++; $display("FAIL abort_valid got %b want 0", o_valid); end
        compared++; if (o_result !== 32'd0) begin mismatched++; $display("FAIL abort_result got %h want 0", o_result); end
        compared++; if (o_div_by_zero !== 1'b0) begin mismatched++; $display("FAIL abort_dz got %b want 0", o_div_by_zero); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 36; n++) begin
            @(posedge clk); #1;
            if (o_valid || o_busy) seen++;
        end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL abort_activity got %0d want 0", seen); end
        run_op(32'd9, 32'd3, 2'd1, res, dz, lat);
        compared++; if (res !== 32'd3) begin mismatched++; $display("FAIL abort_after got %h want 3", res); end
        compared++; if (lat != 33) begin mismatched++; $display("FAIL abort_after_latency got %0d want 33", lat); end
    endtask

    task automatic test_random;
        logic [31:0] a, b, res;
        logic [1:0] op;
        logic [32:0] exp;
        logic dz;
        int lat;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3, 4: b = 32'($urandom_range(1, 15));
                5:       b = 32'h8000_0000;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            exp = model(a, b, op);
            run_op(a, b, op, res, dz, lat);
            compared++; if (res !== exp[31:0]) begin mismatched++; $display("FAIL rand_%0d op%0d %h/%h result got %h want %h", i, op, a, b, res, exp[31:0]); end
            compared++; if (dz !== exp[32]) begin mismatched++; $display("FAIL rand_%0d dz got %b want %b", i, dz, exp[32]); end
            compared++; if (lat != (exp[32] ? 1 : 33)) begin mismatched++; $display("FAIL rand_%0d latency got %0d want %0d", i, lat, exp[32] ? 1 : 33); end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed;
        test_div_by_zero;
        test_overflow;
        test_handshake;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rv16_div.md
# rv16_div

Iterative integer divide unit for the RV16 core. It implements the M-extension DIV/DIVU/REM/REMU operations, complementing the single-cycle MUL in the ALU. It accepts one request at a time from the execute stage over a start/busy/valid handshake and computes the result by restoring division, one quotient bit per clock.

## Interface
- XLEN, 32, operand and result width.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  request strobe; accepted only when o_busy=0.
- i_operand_a  input  XLEN  dividend.
- i_operand_b  input  XLEN  divisor.
- i_div_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- o_busy  output  1  request in progress; new starts are ignored while high.
- o_valid  output  1  one-cycle pulse; o_result is valid.
- o_result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- o_div_by_zero  output  1  divisor was zero for the request being reported.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if i_start=1, latch the operation, the operand signs and the operand magnitudes. Signed ops use the two's-complement absolute value; unsigned ops use the raw operands. Clear the partial remainder and set the iteration count to 0. If i_operand_b=0, go to DONE; otherwise go to CALC.
- CALC: each cycle, shift {remainder, quotient} left by 1 and trial-subtract the divisor magnitude from the upper XLEN+1 bits. If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore. After XLEN iterations (count XLEN-1 reached), go to DONE.
- DONE: register o_result and o_div_by_zero, pulse o_valid for one cycle, then go to IDLE.
- Sign correction for signed ops, applied in DONE:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (RISC-V semantics):
  - Quotient = all ones for both DIV and DIVU.
  - Remainder = i_operand_a unmodified.
  - o_div_by_zero=1.
- Signed overflow (a=0x8000_0000, b=0xFFFF_FFFF, DIV): the normal path yields quotient 0x8000_0000 and remainder 0. No special case is required; the result must match these values.
- o_result and o_div_by_zero hold their values from the o_valid pulse until the next o_valid pulse.
- i_start while o_busy=1 is ignored and has no effect on the operation in progress.
- Operands need not be held after the accept edge.

## Timing
- Reset values: o_busy=0, o_valid=0, o_result=0, o_div_by_zero=0, state IDLE. All internal registers are cleared.
- Normal request accepted at edge N:
  - o_busy=1 from after edge N until after edge N+XLEN+1.
  - o_valid=1 for exactly the cycle after edge N+XLEN+1 (33-cycle latency at XLEN=32).
- Divide-by-zero request accepted at edge N: o_valid=1 in the cycle after edge N+1 (1-cycle latency).
- o_busy is low during the o_valid cycle. A new i_start in that cycle is accepted at the next edge, giving back-to-back operation with no bubble.
- Reset asserted mid-operation aborts immediately: outputs return to their reset values, there is no o_valid pulse, and the block is in IDLE when reset deasserts.
- The result path is combinational from internal registers only. No input reaches any output combinationally.

## Test plan
- DIVU 100 / 7 -> o_valid exactly 33 cycles after the accept edge; o_result=14. REMU 100 / 7 -> o_result=2. o_div_by_zero=0 in both cases.
- DIV -7 / 2 -> o_result=0xFFFF_FFFD (-3). REM -7 / 2 -> 0xFFFF_FFFF (-1). REM 7 / -2 -> 1. DIVU 0xFFFF_FFF9 / 2 -> 0x7FFF_FFFC.
- DIVU 5 / 0 -> o_valid after 1 cycle; o_result=0xFFFF_FFFF; o_div_by_zero=1. REM -5 / 0 -> o_result=0xFFFF_FFFB.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> o_result=0x8000_0000. REM with the same operands -> 0.
- Handshake: pulse i_start with different operands at cycles 5 and 20 after an accepted start -> both ignored and the first result is unchanged. Assert a new i_start in the o_valid cycle -> accepted, and its o_valid follows 33 cycles later.
- Drop i_rst_n at cycle 10 of a CALC -> all outputs 0 immediately, no o_valid pulse. After release, DIVU 9 / 3 -> o_result=3.
